// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// State encoding and frame geometry used by uart_rx and its bench.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        UART_RX_IDLE      = 3'd0,
        UART_RX_START     = 3'd1,
        UART_RX_DATA      = 3'd2,
        UART_RX_STOP      = 3'd3,
        UART_RX_WAIT_HIGH = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte channel out of the UART receiver.
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous input.
// RST_VAL sets the value both stages take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, one-entry
// valid/ready holding register with framing and overrun error pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample
// START     | counting to start-bit centre, rejecting glitches
// DATA      | sampling data bits LSB first
// STOP      | sampling stop bit, deliver or flag framing error
// WAIT_HIGH | after framing error, wait for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_enable,
    input  logic        rx,
    uart_rx_if.master   rx_bus,
    output logic        frame_err,
    output logic        overrun_err
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_rx_state_e       state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 stop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UART_RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        stop_ok = 1'b0;

        if (valid_q && rx_bus.rx_ready) begin
            valid_d = 1'b0;
        end

        if (rx_enable) begin
            unique case (state_q)
                UART_RX_IDLE: begin
                    if (!rx_s) begin
                        state_d = UART_RX_START;
                        tick_d  = '0;
                    end
                end
                UART_RX_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? UART_RX_IDLE : UART_RX_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                UART_RX_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = UART_RX_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                UART_RX_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            stop_ok = 1'b1;
                            state_d = UART_RX_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = UART_RX_WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                UART_RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = UART_RX_IDLE;
                    end
                end
                default: state_d = UART_RX_IDLE;
            endcase
        end

        // A byte may land in the same cycle the old one is drained.
        if (stop_ok) begin
            if (!valid_q || rx_bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_bus.rx_data  = data_q;
    assign rx_bus.rx_valid = valid_q;
    assign frame_err       = ferr_q;
    assign overrun_err     = ovr_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames, sitting directly downstream of the baud-rate generator. It consumes the generator's 16x-oversample tick (`rx_enable`) and a raw serial line. It recovers each byte with mid-bit sampling and presents it on a one-entry valid/ready output register. It flags framing and overrun errors.

## Interface
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, 16: `rx_enable` ticks per bit period; must be even and ≥ 4.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_enable`  in  1  oversample tick from the baud generator; one `clk` cycle high per tick.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  `DATA_BITS`  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: byte completed while holding register full and not being drained.

## Operation
- Input sync: `rx` passes through 2 flip-flops to give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- Counters: `tick_cnt` is `$clog2(OVERSAMPLE)` bits; `bit_cnt` is `$clog2(DATA_BITS+1)` bits.
  - Both advance only on cycles where `rx_enable`=1.
  - Between ticks, all state holds.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a tick with `rx_s`=0, go to START with `tick_cnt`=0.
  - START: on each tick, `tick_cnt`++.
    - When a tick arrives with `tick_cnt`==OVERSAMPLE/2−1 and `rx_s`=0 (start-bit centre), go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
    - If `rx_s`=1 at that point, treat it as a glitch and return to IDLE with nothing reported.
  - DATA: on each tick, `tick_cnt`++.
    - At `tick_cnt`==OVERSAMPLE−1: shift `rx_s` into the shift register MSB (shift right), set `tick_cnt`=0, `bit_cnt`++.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: at `tick_cnt`==OVERSAMPLE−1, sample `rx_s`.
    - `rx_s`=1: deliver the byte and go to IDLE.
    - `rx_s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: on a tick with `rx_s`=1, go to IDLE. A held-low line (break) produces no new frames.
- Delivery on the stop-sample cycle:
  - If `rx_valid`=0, or `rx_valid`=1 and `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: drop the new byte, keep the old `rx_data`, pulse `overrun_err`.
- Handshake:
  - A transfer occurs in any cycle with `rx_valid`=1 and `rx_ready`=1.
  - `rx_valid` clears on the following cycle unless a new byte loads in the same cycle.
  - `rx_ready` is ignored while `rx_valid`=0.

## Timing
- Reset values: FSM=IDLE, counters=0, shift register=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, sync flops=1.
- Reset mid-frame aborts immediately. The next frame needs a fresh falling edge seen from IDLE.
- Sync latency: 2 `clk`.
- Start detection happens on the first tick after `rx_s` falls. Sampling therefore lands 8–9 ticks into each bit (within one tick of centre).
- `rx_valid` rises the `clk` cycle after the stop-bit sample tick.
- Total frame latency is about 9.5 bit periods from the start-bit falling edge to `rx_valid`.
- `frame_err` and `overrun_err` are registered and high for exactly one `clk` cycle. They are never asserted together, because a framing error never delivers a byte.

## Structure
- Package `uart_pkg`: FSM state enum (`UART_RX_IDLE` .. `UART_RX_WAIT_HIGH`), `UART_OVERSAMPLE`=16, `UART_DATA_BITS`=8.
- Sub-module `sync_2ff`: 2-stage synchroniser with a reset-value parameter (1 here). Reused later for other async inputs.
- The receiver does not instantiate the baud generator; the top level connects the generator's `rx_enable` output to this block's `rx_enable` input.

## Test plan
- Frame 0xA5 (bits LSB-first 1,0,1,0,0,1,0,1), stop=1, `rx_ready` held 1 -> one `rx_valid` pulse with `rx_data`=0xA5, no errors.
- Back-to-back frames 0x00 then 0xFF with minimum 1-bit stop -> two deliveries, `rx_data`=0x00 then 0xFF.
- `rx` low for 3 ticks then high -> FSM returns to IDLE, no `rx_valid`, no errors.
- Frame 0x3C with stop bit 0, then line held low 40 bit periods, then a valid 0x11 frame -> single `frame_err` pulse, no delivery during break, then `rx_data`=0x11.
- Frames 0x12 and 0x34 with `rx_ready`=0 throughout -> `rx_data`=0x12 `rx_valid`=1, one `overrun_err` at the second stop sample. Raising `rx_ready` then gives one transfer of 0x12 and `rx_valid`=0.
- Assert `rst` during bit 4 of a frame, release, send 0x5A -> all outputs at reset values during reset, then clean delivery of 0x5A.
